// File: rtl/data_mem_hs.sv
// Byte-addressable data memory for the RISC-V load/store path, with valid/ready
// request and response channels and a programmable number of wait states.
module data_mem_hs #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_CHECK  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // the sender keeps valid and its payload stable until that edge.

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic           err_q;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           f3_bad, misaligned, out_of_range, req_err;
  logic           access, mem_we;
  logic [AW-1:0]  idx;
  logic [3:0]     be;
  logic [31:0]    wd_lanes, rd_word, load_data;
  logic [7:0]     rd_byte;
  logic [15:0]    rd_half;

  assign dbg_state = state;

  // Error verdict is formed from the live request and latched at accept.
  always_comb begin
    f3_bad = 1'b0;
    case (req_func3)
      3'b000, 3'b001, 3'b010: f3_bad = 1'b0;
      3'b100, 3'b101:         f3_bad = req_we;
      default:                f3_bad = 1'b1;
    endcase
    misaligned   = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_func3 == 3'b010) && (req_addr[1:0] != 2'b00));
    out_of_range = (ADDR_CHECK != 0) && (req_addr >= ADDR_LIMIT);
    req_err      = f3_bad | misaligned | out_of_range;
  end

  assign idx     = addr_q[AW+1:2];
  assign access  = (state == S_WAIT) && (cnt == 4'd0);
  assign mem_we  = access && we_q && !err_q;
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    be       = 4'b1111;
    wd_lanes = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be       = 4'b0001 << addr_q[1:0];
        wd_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{wdata_q[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    load_data = rd_word;
    case (f3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = rd_word;
    endcase
  end

  // RAM is deliberately unreset; the FSM's async reset alone blocks pending stores.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      err_q      <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_func3;
            addr_q    <= req_addr[AW+1:0];
            wdata_q   <= req_wdata;
            err_q     <= req_err;
            cnt       <= 4'(WAIT_STATES);
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            resp_rdata <= (we_q || err_q) ? 32'd0 : load_data;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: begin
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: two instances (address wrap and address check) share
// stimulus and are compared against a byte-level reference model.
module tb_data_mem_hs;

  localparam int WS     = 2;
  localparam int DEPTH  = 64;
  localparam int NBYTES = 4 * DEPTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_func3 = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;

  logic        req_ready0, resp_valid0, resp_err0, req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata0, resp_rdata1;
  logic [1:0]  dbg_state0, dbg_state1;

  data_mem_hs #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .ADDR_CHECK(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_rdata(resp_rdata0),
    .resp_err(resp_err0), .dbg_state(dbg_state0));

  data_mem_hs #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .ADDR_CHECK(1)) dut_ac (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_rdata(resp_rdata1),
    .resp_err(resp_err1), .dbg_state(dbg_state1));

  // scoreboard
  int vec_cnt = 0;
  int mis_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mb [2][NBYTES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, accesses as sized byte runs.
  task automatic model_access(input int inst, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
    int size;
    bit sgn, legal;
    logic [31:0] v;
    size = 4; sgn = 0; legal = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; legal = !we; end
      3'd5: begin size = 2; legal = !we; end
      default: legal = 0;
    endcase
    err = !legal || (int'(addr % size) != 0) || (inst == 1 && addr >= NBYTES);
    rdata = 32'd0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < size; b++) mb[inst][int'((addr + b) % NBYTES)] = wdata[8*b +: 8];
      end else begin
        v = 32'd0;
        for (int b = 0; b < size; b++) v = v | (32'(mb[inst][int'((addr + b) % NBYTES)]) << (8*b));
        if (sgn && v[8*size-1]) for (int k = 8*size; k < 32; k++) v[k] = 1'b1;
        rdata = v;
      end
    end
  endtask

  // driver tasks
  task automatic accept_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit early_rr);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready0 && n < 50) begin @(negedge clk); n++; end
    chk("req_ready before accept", 32'(req_ready0), 32'd1);
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = addr; req_wdata = wdata;
    resp_ready = early_rr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready after accept", 32'(req_ready0), 32'd0);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency edges", 32'(n), 32'(WS + 1));
    chk("dut_ac resp_valid", 32'(resp_valid1), 32'd1);
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input bit early_rr,
                         output logic [31:0] rd0, output logic e0);
    logic [31:0] rd1, m_rd;
    logic e1, m_err;
    accept_req(we, f3, addr, wdata, early_rr);
    wait_resp();
    rd0 = resp_rdata0; e0 = resp_err0; rd1 = resp_rdata1; e1 = resp_err1;
    if (hold > 0) begin
      resp_ready = 1'b0;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        chk("hold resp_valid", 32'(resp_valid0), 32'd1);
        chk("hold rdata", resp_rdata0, rd0);
        chk("hold err", 32'(resp_err0), 32'(e0));
        chk("hold req_ready", 32'(req_ready0), 32'd0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_valid after handshake", 32'(resp_valid0), 32'd0);
    chk("req_ready after handshake", 32'(req_ready0), 32'd1);
    chk("idle after handshake", 32'(dbg_state0), 32'd0);
    model_access(0, we, f3, addr, wdata, m_rd, m_err);
    exp_q.push_back(m_rd);
    chk("dut rdata vs model", rd0, exp_q.pop_front());
    chk("dut err vs model", 32'(e0), 32'(m_err));
    model_access(1, we, f3, addr, wdata, m_rd, m_err);
    exp_q.push_back(m_rd);
    chk("dut_ac rdata vs model", rd1, exp_q.pop_front());
    chk("dut_ac err vs model", 32'(e1), 32'(m_err));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready0), 32'd1);
    chk({tag, " resp_valid"}, 32'(resp_valid0), 32'd0);
    chk({tag, " rdata"}, resp_rdata0, 32'd0);
    chk({tag, " err"}, 32'(resp_err0), 32'd0);
    chk({tag, " state"}, 32'(dbg_state0), 32'd0);
    chk({tag, " ac resp_valid"}, 32'(resp_valid1), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #2_000_000;
    mis_cnt++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old;
    logic e;
    logic [2:0] f3;
    logic [31:0] addr;
    int sel;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    tbl[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 3'd0, 32'h13,  32'h80,       32'h0,        1'b0};
    tbl[3]  = '{1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
    tbl[4]  = '{1'b0, 3'd4, 32'h13,  32'h0,        32'h00000080, 1'b0};
    tbl[5]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
    tbl[6]  = '{1'b1, 3'd1, 32'h11,  32'h1234,     32'h0,        1'b1};
    tbl[7]  = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
    tbl[8]  = '{1'b0, 3'd2, 32'h12,  32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b0, 3'd3, 32'h10,  32'h0,        32'h0,        1'b1};
    tbl[10] = '{1'b0, 3'd5, 32'h12,  32'h0,        32'h000080AD, 1'b0};
    tbl[11] = '{1'b0, 3'd1, 32'h10,  32'h0,        32'hFFFFBEEF, 1'b0};
    tbl[12] = '{1'b1, 3'd4, 32'h14,  32'hFF,       32'h0,        1'b1};
    tbl[13] = '{1'b1, 3'd1, 32'h12,  32'hAAAA5555, 32'h0,        1'b0};
    tbl[14] = '{1'b0, 3'd2, 32'h10,  32'h0,        32'h5555BEEF, 1'b0};
    tbl[15] = '{1'b1, 3'd2, 32'h100, 32'hCAFEF00D, 32'h0,        1'b0};
    tbl[16] = '{1'b0, 3'd2, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0};
    tbl[17] = '{1'b0, 3'd1, 32'h13,  32'h0,        32'h0,        1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Give every word a known value so the model and RAM agree.
    for (int w = 0; w < DEPTH; w++) run_txn(1'b1, 3'd2, 32'(4 * w), $urandom, 0, 1'b1, rd, e);

    for (int i = 0; i < 18; i++) begin
      run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, i % 3, 1'(i % 2), rd, e);
      chk($sformatf("table[%0d] rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("table[%0d] err", i), 32'(e), 32'(tbl[i].exp_err));
    end

    // Out-of-range store flagged only by the checking instance.
    accept_req(1'b1, 3'd2, 32'h104, 32'h5A5A5A5A, 1'b0);
    wait_resp();
    chk("ac oor store err", 32'(resp_err1), 32'd1);
    chk("wrap store err", 32'(resp_err0), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    model_access(0, 1'b1, 3'd2, 32'h104, 32'h5A5A5A5A, rd, e);
    model_access(1, 1'b1, 3'd2, 32'h104, 32'h5A5A5A5A, rd, e);

    // Response held for 5 cycles.
    run_txn(1'b0, 3'd2, 32'h10, 32'h0, 5, 1'b0, rd, e);
    chk("held load data", rd, 32'h5555BEEF);

    // Reset during WAIT drops the pending store.
    old = {mb[0][35], mb[0][34], mb[0][33], mb[0][32]};
    accept_req(1'b1, 3'd2, 32'h20, ~old, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset in wait");
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, rd, e);
    chk("store dropped by reset", rd, old);

    // Reset during RESP keeps the committed store.
    accept_req(1'b1, 3'd2, 32'h24, 32'h0BADF00D, 1'b0);
    wait_resp();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset in resp");
    @(negedge clk);
    rst_n = 1'b1;
    model_access(0, 1'b1, 3'd2, 32'h24, 32'h0BADF00D, rd, e);
    model_access(1, 1'b1, 3'd2, 32'h24, 32'h0BADF00D, rd, e);
    run_txn(1'b0, 3'd2, 32'h24, 32'h0, 0, 1'b1, rd, e);
    chk("committed store survives reset", rd, 32'h0BADF00D);

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 3);
      f3 = (sel != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        else if (f3 == 3'd2) addr[1:0] = 2'b00;
      end
      run_txn(1'($urandom_range(0, 1)), f3, addr, $urandom, $urandom_range(0, 2),
              1'($urandom_range(0, 1)), rd, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
